// File: rtl/dmem_arbiter_if.sv
// Single-beat requester bus between one data-memory client and the arbiter.
// Carries the request (req/we/addr/wdata) and the grant plus read return.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU port (m0) and the loader/DMA port (m1).
// Latency: grant in the request cycle when uncontended; read data one cycle after the grant.
// Backpressure: a requester holds req stable until gnt; round-robin with bounded bursts.
module dmem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_spo
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  // Only the word-address bits reach the memory; the rest wrap or are byte offset.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0.addr[31:ADDR_W+2], m0.addr[1:0],
                              m1.addr[31:ADDR_W+2], m1.addr[1:0]};

  // Pick at most one winner per cycle; the current owner keeps the memory until
  // it stops asking or has used its burst while the other side is waiting.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        OWN0: begin
          if (m0.req && (!m1.req || cnt < CNT_MAX)) gnt0 = 1'b1;
          else if (m1.req)                          gnt1 = 1'b1;
        end
        OWN1: begin
          if (m1.req && (!m0.req || cnt < CNT_MAX)) gnt1 = 1'b1;
          else if (m0.req)                          gnt0 = 1'b1;
        end
        default: begin
          if (m0.req)      gnt0 = 1'b1;
          else if (m1.req) gnt1 = 1'b1;
        end
      endcase
    end
  end

  // Steer the winner onto the memory; an idle cycle drives all zeros.
  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_d  = '0;
    if (gnt0) begin
      mem_a  = m0.addr[ADDR_W+1:2];
      mem_we = m0.we;
      mem_d  = m0.wdata;
    end else if (gnt1) begin
      mem_a  = m1.addr[ADDR_W+1:2];
      mem_we = m1.we;
      mem_d  = m1.wdata;
    end
  end

  // Ownership/burst tracking plus capture of the async read data at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~m0.we;
      rvalid1 <= gnt1 & ~m1.we;
      if (gnt0 && !m0.we) rdata0 <= mem_spo;
      if (gnt1 && !m1.we) rdata1 <= mem_spo;
      if (gnt0) begin
        state <= OWN0;
        if (state != OWN0)      cnt <= CNT_W'(1);
        else if (cnt < CNT_MAX) cnt <= cnt + 1'b1;
      end else if (gnt1) begin
        state <= OWN1;
        if (state != OWN1)      cnt <= CNT_W'(1);
        else if (cnt < CNT_MAX) cnt <= cnt + 1'b1;
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model on the mem side, two requester buses,
// expected read returns queued at grant time and consumed when rvalid is due.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_d;
  logic [31:0] mem_spo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          who;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] mem [0:16383];

  dmem_arbiter_if #(.DATA_W(32)) m0_bus ();
  dmem_arbiter_if #(.DATA_W(32)) m1_bus ();

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .mem_a   (mem_a),
    .mem_we  (mem_we),
    .mem_d   (mem_d),
    .mem_spo (mem_spo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int w);
    return 32'hA5C3_0000 | 32'(w);
  endfunction

  // Memory model: async read, write at the clock edge.
  assign mem_spo = mem[mem_a];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = pat(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_a] <= mem_d;
    end
  end

  // Read-return consumer and requester hold-stable watchdog.
  logic        p_rst = 1'b1;
  logic        p0_req, p0_gnt, p0_we, p1_req, p1_gnt, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      total++;
      if (e.who == 0) begin
        if (m0_bus.rvalid !== 1'b1 || m1_bus.rvalid !== 1'b0 || m0_bus.rdata !== e.data) begin
          bad++;
          $display("FAIL rd_ret_m0 cyc=%0d: rv0=%b rv1=%b rdata=%h, want rv0=1 rv1=0 rdata=%h",
                   cyc, m0_bus.rvalid, m1_bus.rvalid, m0_bus.rdata, e.data);
        end
      end else begin
        if (m1_bus.rvalid !== 1'b1 || m0_bus.rvalid !== 1'b0 || m1_bus.rdata !== e.data) begin
          bad++;
          $display("FAIL rd_ret_m1 cyc=%0d: rv0=%b rv1=%b rdata=%h, want rv0=0 rv1=1 rdata=%h",
                   cyc, m0_bus.rvalid, m1_bus.rvalid, m1_bus.rdata, e.data);
        end
      end
    end else begin
      total++;
      if (m0_bus.rvalid !== 1'b0 || m1_bus.rvalid !== 1'b0) begin
        bad++;
        $display("FAIL no_rvalid cyc=%0d: rv0=%b rv1=%b, want 0 0", cyc, m0_bus.rvalid, m1_bus.rvalid);
      end
    end
    if (!p_rst && p0_req && !p0_gnt) begin
      total++;
      if (m0_bus.req !== 1'b1 || m0_bus.we !== p0_we || m0_bus.addr !== p0_addr || m0_bus.wdata !== p0_wdata) begin
        bad++;
        $display("FAIL m0_hold cyc=%0d: req=%b addr=%h, want req=1 addr=%h", cyc, m0_bus.req, m0_bus.addr, p0_addr);
      end
    end
    if (!p_rst && p1_req && !p1_gnt) begin
      total++;
      if (m1_bus.req !== 1'b1 || m1_bus.we !== p1_we || m1_bus.addr !== p1_addr || m1_bus.wdata !== p1_wdata) begin
        bad++;
        $display("FAIL m1_hold cyc=%0d: req=%b addr=%h, want req=1 addr=%h", cyc, m1_bus.req, m1_bus.addr, p1_addr);
      end
    end
    p_rst = rst;
    p0_req = m0_bus.req; p0_gnt = m0_bus.gnt; p0_we = m0_bus.we; p0_addr = m0_bus.addr; p0_wdata = m0_bus.wdata;
    p1_req = m1_bus.req; p1_gnt = m1_bus.gnt; p1_we = m1_bus.we; p1_addr = m1_bus.addr; p1_wdata = m1_bus.wdata;
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_bus.req = 1'b1; m0_bus.we = 1'b0; m0_bus.addr = 32'h40; m0_bus.wdata = 32'h0;
    m1_bus.req = 1'b1; m1_bus.we = 1'b0; m1_bus.addr = 32'h80; m1_bus.wdata = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (m0_bus.gnt !== 1'b0 || m1_bus.gnt !== 1'b0 || mem_we !== 1'b0 || mem_a !== 14'd0 || mem_d !== 32'd0) begin
        bad++;
        $display("FAIL rst_hold: gnt0=%b gnt1=%b we=%b a=%h d=%h, want all 0",
                 m0_bus.gnt, m1_bus.gnt, mem_we, mem_a, mem_d);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (m0_bus.gnt !== 1'b1 || m1_bus.gnt !== 1'b0 || mem_a !== 14'd16) begin
      bad++;
      $display("FAIL rst_release: gnt0=%b gnt1=%b a=%h, want 1 0 010", m0_bus.gnt, m1_bus.gnt, mem_a);
    end
    sbq.push_back('{0, pat(16), cyc + 1});
    @(posedge clk); #1;
    m0_bus.req = 1'b0;
    @(negedge clk);
    total++;
    if (m1_bus.gnt !== 1'b1 || mem_a !== 14'd32) begin
      bad++;
      $display("FAIL rst_m1_next: gnt1=%b a=%h, want 1 020", m1_bus.gnt, mem_a);
    end
    sbq.push_back('{1, pat(32), cyc + 1});
    idle_cycle();
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    m0_bus.req = 1'b1; m0_bus.we = 1'b1; m0_bus.addr = 32'h10; m0_bus.wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (m0_bus.gnt !== 1'b1 || mem_a !== 14'd4 || mem_we !== 1'b1 || mem_d !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr: gnt=%b a=%h we=%b d=%h, want 1 004 1 deadbeef", m0_bus.gnt, mem_a, mem_we, mem_d);
    end
    // High bits and byte offset must be dropped: this still hits word 4.
    @(posedge clk); #1;
    m0_bus.we = 1'b0; m0_bus.addr = 32'hABCD0012;
    @(negedge clk);
    total++;
    if (m0_bus.gnt !== 1'b1 || mem_a !== 14'd4 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL rd_wrap: gnt=%b a=%h we=%b, want 1 004 0", m0_bus.gnt, mem_a, mem_we);
    end
    sbq.push_back('{0, 32'hDEADBEEF, cyc + 1});
    @(posedge clk); #1;
    m0_bus.req = 1'b0;
    @(negedge clk);
    total++;
    if (m0_bus.gnt !== 1'b0 || mem_a !== 14'd0 || mem_we !== 1'b0 || mem_d !== 32'd0 || m0_bus.rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_idle: gnt=%b a=%h we=%b d=%h rdata=%h, want 0 000 0 0 deadbeef",
               m0_bus.gnt, mem_a, mem_we, mem_d, m0_bus.rdata);
    end
    idle_cycle();
  endtask

  task automatic test_burst();
    int who;
    @(posedge clk); #1;
    m0_bus.req = 1'b1; m0_bus.we = 1'b0; m0_bus.addr = 32'h100;
    m1_bus.req = 1'b1; m1_bus.we = 1'b0; m1_bus.addr = 32'h200;
    for (int i = 0; i < 13; i++) begin
      if (i == 12) begin
        @(posedge clk); #1;
        m0_bus.req = 1'b0;
      end else if (i > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      who = (i >= 4 && i < 8) || i == 12 ? 1 : 0;
      total++;
      if (m0_bus.gnt !== (who == 0) || m1_bus.gnt !== (who == 1)) begin
        bad++;
        $display("FAIL burst[%0d]: gnt0=%b gnt1=%b, want owner m%0d", i, m0_bus.gnt, m1_bus.gnt, who);
      end
      sbq.push_back('{who, (who == 0) ? pat(64) : pat(128), cyc + 1});
    end
    idle_cycle();
  endtask

  task automatic test_owner_drop();
    @(posedge clk); #1;
    m0_bus.req = 1'b1; m0_bus.we = 1'b0; m0_bus.addr = 32'h300;
    @(negedge clk);
    sbq.push_back('{0, pat(192), cyc + 1});
    @(posedge clk); #1;
    @(negedge clk);
    sbq.push_back('{0, pat(192), cyc + 1});
    @(posedge clk); #1;
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b1; m1_bus.we = 1'b0; m1_bus.addr = 32'h304;
    @(negedge clk);
    total++;
    if (m1_bus.gnt !== 1'b1 || m0_bus.gnt !== 1'b0 || dut.cnt !== 3'd2) begin
      bad++;
      $display("FAIL drop_switch: gnt0=%b gnt1=%b cnt=%0d, want 0 1 2", m0_bus.gnt, m1_bus.gnt, dut.cnt);
    end
    sbq.push_back('{1, pat(193), cyc + 1});
    @(posedge clk); #1;
    m1_bus.req = 1'b0;
    @(negedge clk);
    total++;
    if (dut.cnt !== 3'd1) begin
      bad++;
      $display("FAIL drop_cnt: cnt=%0d, want 1", dut.cnt);
    end
  endtask

  task automatic test_sole_requester();
    int exp_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      m1_bus.req = 1'b1; m1_bus.we = 1'b0; m1_bus.addr = 32'(i * 4);
      @(negedge clk);
      exp_cnt = (i < 4) ? i : 4;
      total++;
      if (m1_bus.gnt !== 1'b1 || m0_bus.gnt !== 1'b0 || m0_bus.rdata !== pat(192) || dut.cnt !== 3'(exp_cnt)) begin
        bad++;
        $display("FAIL sole[%0d]: gnt1=%b gnt0=%b rdata0=%h cnt=%0d, want 1 0 %h %0d",
                 i, m1_bus.gnt, m0_bus.gnt, m0_bus.rdata, dut.cnt, pat(192), exp_cnt);
      end
      sbq.push_back('{1, (i == 4) ? 32'hDEADBEEF : pat(i), cyc + 1});
    end
    idle_cycle();
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    m1_bus.req = 1'b1; m1_bus.we = 1'b0; m1_bus.addr = 32'h40;
    @(negedge clk);
    total++;
    if (m1_bus.gnt !== 1'b1) begin
      bad++;
      $display("FAIL midrst_gnt: gnt1=%b, want 1", m1_bus.gnt);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m0_bus.req = 1'b1; m0_bus.we = 1'b0; m0_bus.addr = 32'h44;
    @(negedge clk);
    total++;
    if (m1_bus.rvalid !== 1'b0 || dut.cnt !== 3'd0 || m0_bus.gnt !== 1'b1 || m1_bus.gnt !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after: rv1=%b cnt=%0d gnt0=%b gnt1=%b, want 0 0 1 0",
               m1_bus.rvalid, dut.cnt, m0_bus.gnt, m1_bus.gnt);
    end
    sbq.push_back('{0, pat(17), cyc + 1});
    @(posedge clk); #1;
    m0_bus.req = 1'b0;
    @(negedge clk);
    total++;
    if (m1_bus.gnt !== 1'b1) begin
      bad++;
      $display("FAIL midrst_m1: gnt1=%b, want 1", m1_bus.gnt);
    end
    sbq.push_back('{1, pat(16), cyc + 1});
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = 32'h0; m0_bus.wdata = 32'h0;
    m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = 32'h0; m1_bus.wdata = 32'h0;
    test_reset();
    test_write_read();
    test_burst();
    test_owner_drop();
    test_sole_requester();
    test_mid_reset();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d reads outstanding, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
